// File: rtl/axil_regfile_pkg.sv
// Shared types and constants for the AXI-Lite slave register file.
// Holds FSM encodings, the miss-read pattern and the default window base.
package axil_regfile_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;
    localparam logic [31:0] MISS_DATA     = 32'hBAD0_ADD0;

    typedef enum logic {
        WS_COLLECT,
        WS_RESP
    } ws_t;

    typedef enum logic {
        RS_IDLE,
        RS_DATA
    } rs_t;

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI-Lite bus bundle between a master and the register-file slave.
// Clock and reset travel as plain ports beside it.
interface axil_slave_regfile_if;

    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axil_reg_array.sv
// Register storage: one synchronous write port, one combinational read port.
// All words clear to zero on asynchronous reset.
module axil_reg_array #(
    parameter int NUM_REGS = 16,
    parameter int IW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave exposing NUM_REGS 32-bit registers at BASE_ADDR.
// Independent write (collect AW/W, respond) and read (capture, hold) FSMs.
module axil_slave_regfile
    import axil_regfile_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          NUM_REGS  = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    axil_slave_regfile_if.slave s_axi
);

    localparam int          IW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(4 * NUM_REGS);

    ws_t         ws;
    logic        aw_cap;
    logic        w_cap;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic        aw_fire;
    logic        w_fire;
    logic        commit;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] woff;
    logic        whit;

    rs_t         rs;
    logic [31:0] rdata_q;
    logic        ar_fire;
    logic [31:0] roff;
    logic        rhit;
    logic [31:0] rd_word;

    // Readys are gated by reset so nothing is accepted while it is held.
    assign s_axi.S_AXI_AWREADY = !ARESET && (ws == WS_COLLECT) && !aw_cap;
    assign s_axi.S_AXI_WREADY  = !ARESET && (ws == WS_COLLECT) && !w_cap;
    assign s_axi.S_AXI_BVALID  = (ws == WS_RESP);

    assign aw_fire = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_fire  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
    assign commit  = (ws == WS_COLLECT)
                   && (aw_cap || aw_fire)
                   && (w_cap  || w_fire);

    // Bypass the holding registers when a channel lands on the commit edge.
    assign waddr = aw_cap ? awaddr_q : s_axi.S_AXI_AWADDR;
    assign wdata = w_cap  ? wdata_q  : s_axi.S_AXI_WDATA;
    assign woff  = waddr - BASE_ADDR;
    assign whit  = woff < SPAN;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ws       <= WS_COLLECT;
            aw_cap   <= 1'b0;
            w_cap    <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
        end else begin
            unique case (ws)
                WS_COLLECT: begin
                    if (commit) begin
                        aw_cap <= 1'b0;
                        w_cap  <= 1'b0;
                        ws     <= WS_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_cap   <= 1'b1;
                            awaddr_q <= s_axi.S_AXI_AWADDR;
                        end
                        if (w_fire) begin
                            w_cap   <= 1'b1;
                            wdata_q <= s_axi.S_AXI_WDATA;
                        end
                    end
                end
                WS_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        ws <= WS_COLLECT;
                    end
                end
                default: ws <= WS_COLLECT;
            endcase
        end
    end

    assign s_axi.S_AXI_ARREADY = !ARESET && (rs == RS_IDLE);
    assign s_axi.S_AXI_RVALID  = (rs == RS_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;

    assign ar_fire = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign roff    = s_axi.S_AXI_ARADDR - BASE_ADDR;
    assign rhit    = roff < SPAN;

    // Read port sees the pre-edge contents, so a same-edge write returns old data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rs      <= RS_IDLE;
            rdata_q <= '0;
        end else begin
            unique case (rs)
                RS_IDLE: begin
                    if (ar_fire) begin
                        rdata_q <= rhit ? rd_word : MISS_DATA;
                        rs      <= RS_DATA;
                    end
                end
                RS_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rs <= RS_IDLE;
                    end
                end
                default: rs <= RS_IDLE;
            endcase
        end
    end

    axil_reg_array #(
        .NUM_REGS (NUM_REGS),
        .IW       (IW)
    ) u_regs (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (commit && whit),
        .waddr (woff[IW+1:2]),
        .wdata (wdata),
        .raddr (roff[IW+1:2]),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Scoreboard bench for axil_slave_regfile: tasks queue expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axil_slave_regfile;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;

    axil_slave_regfile_if bus ();

    axil_slave_regfile #(
        .BASE_ADDR (32'h0000_1000),
        .NUM_REGS  (16)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (bus)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    logic [31:0] bq [$];
    logic [31:0] rq [$];
    logic [31:0] model [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    always @(negedge ACLK) begin
        if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            chk("b_expected", 32'(bq.size() > 0), 32'd1);
            if (bq.size() > 0) void'(bq.pop_front());
        end
        if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            chk("r_expected", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) chk("rdata", bus.S_AXI_RDATA, rq.pop_front());
        end
    end

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - 32'h1000;
        if (off < 32'd64) model[off[5:2]] = d;
    endfunction

    // Write with AW and W driven together; BREADY held low for k cycles.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int k);
        logic aw_ok = 1'b0;
        logic w_ok = 1'b0;
        int n = 0;
        bq.push_back(a);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = (k == 0);
        while (!(aw_ok && w_ok) && n < 20) begin
            @(negedge ACLK);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_ok = 1'b1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_ok = 1'b1;
            step();
            if (aw_ok) bus.S_AXI_AWVALID = 1'b0;
            if (w_ok) bus.S_AXI_WVALID = 1'b0;
            n++;
        end
        chk("aw_w_accept", 32'(aw_ok && w_ok), 32'd1);
        model_wr(a, d);
        for (int i = 0; i < k; i++) begin
            @(negedge ACLK);
            chk("b_stall_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
            chk("b_stall_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
            chk("b_stall_wready", 32'(bus.S_AXI_WREADY), 32'd0);
            step();
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("b_valid", 32'(bus.S_AXI_BVALID), 32'd1);
        step();
    endtask

    // Read expecting e; RREADY held low for k cycles after RVALID.
    task automatic rd(input logic [31:0] a, input logic [31:0] e, input int k);
        logic ok = 1'b0;
        int n = 0;
        rq.push_back(e);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = (k == 0);
        while (!ok && n < 20) begin
            @(negedge ACLK);
            ok = bus.S_AXI_ARREADY;
            step();
            n++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        chk("ar_accept", 32'(ok), 32'd1);
        for (int i = 0; i < k; i++) begin
            @(negedge ACLK);
            chk("r_stall_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
            chk("r_stall_rdata", bus.S_AXI_RDATA, e);
            chk("r_stall_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
            step();
        end
        bus.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        chk("r_valid", 32'(bus.S_AXI_RVALID), 32'd1);
        step();
    endtask

    task automatic rd_all;
        for (int i = 0; i < 16; i++) begin
            rd(32'h1000 + 32'(i * 4), model[i], 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;

        repeat (2) @(negedge ACLK);
        chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        chk("rst_wready", 32'(bus.S_AXI_WREADY), 32'd0);
        chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        chk("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        chk("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        step();
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rel_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        chk("rel_wready", 32'(bus.S_AXI_WREADY), 32'd1);
        chk("rel_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        step();

        wr(32'h1000, 32'hDEAD_BEEF, 0);
        rd(32'h1000, 32'hDEAD_BEEF, 0);

        // W first, AW four cycles later.
        bq.push_back(32'h1004);
        bus.S_AXI_WDATA  = 32'h1234_5678;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        chk("split_wready_first", 32'(bus.S_AXI_WREADY), 32'd1);
        step();
        bus.S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("split_wready_low", 32'(bus.S_AXI_WREADY), 32'd0);
            chk("split_bvalid_low", 32'(bus.S_AXI_BVALID), 32'd0);
            step();
        end
        bus.S_AXI_AWADDR  = 32'h1004;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        chk("split_wready_low", 32'(bus.S_AXI_WREADY), 32'd0);
        chk("split_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        step();
        bus.S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        chk("split_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        step();
        model_wr(32'h1004, 32'h1234_5678);
        rd(32'h1004, 32'h1234_5678, 0);

        wr(32'h103C, 32'h0BAD_CAFE, 0);
        rd(32'h103C, 32'h0BAD_CAFE, 0);
        wr(32'h2000, 32'hCAFE_F00D, 0);
        rd(32'h2000, 32'hBAD0_ADD0, 0);
        rd(32'h1040, 32'hBAD0_ADD0, 0);
        rd(32'h0FFC, 32'hBAD0_ADD0, 0);
        rd_all();

        wr(32'h1010, 32'hA5A5_5A5A, 7);
        rd(32'h1010, 32'hA5A5_5A5A, 7);

        // Write commit and read capture on the same edge.
        wr(32'h1008, 32'h0000_0001, 0);
        bq.push_back(32'h1008);
        rq.push_back(32'h0000_0001);
        bus.S_AXI_AWADDR  = 32'h1008;
        bus.S_AXI_WDATA   = 32'h0000_0002;
        bus.S_AXI_ARADDR  = 32'h1008;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        chk("same_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        chk("same_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        step();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        model_wr(32'h1008, 32'h0000_0002);
        @(negedge ACLK);
        chk("same_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        chk("same_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
        step();
        rd(32'h1008, 32'h0000_0002, 0);
        rd(32'h100B, 32'h0000_0002, 0);

        // Reset while a write response is pending; no B is expected.
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_AWADDR  = 32'h100C;
        bus.S_AXI_WDATA   = 32'h0000_0077;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        step();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        @(negedge ACLK);
        chk("pend_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        #1 ARESET = 1'b1;
        #1;
        chk("arst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        chk("arst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        chk("arst_wready", 32'(bus.S_AXI_WREADY), 32'd0);
        chk("arst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        step();
        ARESET = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("post_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        chk("post_wready", 32'(bus.S_AXI_WREADY), 32'd1);
        chk("post_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        chk("post_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        step();
        for (int i = 0; i < 16; i++) model[i] = '0;
        rd_all();

        repeat (3) step();
        chk("bq_empty", 32'(bq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_slave_regfile.md
AXIL_SLAVE_REGFILE -- requirements
Module: axil_slave_regfile

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, base byte address of the register window.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of two, 2..256).
REQ-003 SHALL have port ACLK  input  1  clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port S_AXI_AWADDR  input  32  write byte address.
REQ-006 SHALL have port S_AXI_AWVALID  input  1 and S_AXI_AWREADY  output  1  write-address handshake.
REQ-007 SHALL have port S_AXI_WDATA  input  32  write data.
REQ-008 SHALL have port S_AXI_WVALID  input  1 and S_AXI_WREADY  output  1  write-data handshake.
REQ-009 SHALL have port S_AXI_BVALID  output  1 and S_AXI_BREADY  input  1  write-response handshake.
REQ-010 SHALL have port S_AXI_ARADDR  input  32  read byte address.
REQ-011 SHALL have port S_AXI_ARVALID  input  1 and S_AXI_ARREADY  output  1  read-address handshake.
REQ-012 SHALL have port S_AXI_RDATA  output  32  read data.
REQ-013 SHALL have port S_AXI_RVALID  output  1 and S_AXI_RREADY  input  1  read-data handshake.

Function
REQ-014 SHALL treat a channel as transferred in any cycle where its VALID and READY are both high at the rising edge.
REQ-015 SHALL decode hit when (ADDR - BASE_ADDR) < 4*NUM_REGS (32-bit unsigned), index = (ADDR - BASE_ADDR) >> 2; ADDR[1:0] ignored.
REQ-016 SHALL run write FSM states WS_COLLECT and WS_RESP; reset state WS_COLLECT.
REQ-017 SHALL in WS_COLLECT drive AWREADY = !aw_captured and WREADY = !w_captured, accepting AW and W in either order or the same cycle.
REQ-018 SHALL, on the edge where the second of AW/W is captured, write WDATA to the indexed register if hit (drop silently if miss), clear both captured flags, and enter WS_RESP.
REQ-019 SHALL in WS_RESP drive BVALID=1, AWREADY=0, WREADY=0, and return to WS_COLLECT on the edge where BREADY=1; BVALID deasserts the following cycle.
REQ-020 SHALL give write latency: last of AW/W accepted in cycle N, register updated and BVALID high in cycle N+1; minimum 2 cycles per write.
REQ-021 SHALL run read FSM states RS_IDLE and RS_DATA; reset state RS_IDLE.
REQ-022 SHALL in RS_IDLE drive ARREADY=1, RVALID=0; on AR transfer latch RDATA = indexed register (hit) or 32'hBAD0_ADD0 (miss) and enter RS_DATA.
REQ-023 SHALL in RS_DATA hold RVALID=1 and RDATA stable, ARREADY=0, until RREADY=1, then return to RS_IDLE.
REQ-024 SHALL give read latency: AR transfer in cycle N, RVALID high in cycle N+1.
REQ-025 SHALL run read and write FSMs independently and concurrently.
REQ-026 SHALL, when a read captures and a write commits the same register on the same edge, return the pre-write (old) value.
REQ-027 SHALL never drop or duplicate a transaction under any VALID/READY stall pattern.

Reset
REQ-028 SHALL, while ARESET=1, force AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RDATA=0, all registers 32'h0, captured flags 0, both FSMs to initial states.
REQ-029 SHALL abandon any in-flight transaction on reset assertion with no B or R response issued.
REQ-030 SHALL assert AWREADY, WREADY and ARREADY in the first cycle after ARESET deasserts.

Structure
REQ-031 SHALL place write/read FSM state enums, the miss-read constant 32'hBAD0_ADD0, and the default BASE_ADDR in package axil_regfile_pkg.
REQ-032 SHALL implement storage as one sub-module axil_reg_array (1 synchronous write port, 1 combinational read port, async-reset to zero).

Verification
REQ-033 SHALL cover: AW+W same cycle to 0x1000 data 32'hDEADBEEF, BREADY=1 -> BVALID next cycle; read 0x1000 -> RDATA 32'hDEADBEEF one cycle after AR.
REQ-034 SHALL cover: W at cycle 5, AW (0x1004, 32'h12345678) at cycle 9 -> WREADY low cycles 6-9, BVALID cycle 10; read 0x1004 -> 32'h12345678.
REQ-035 SHALL cover: write 0x2000 (miss) -> BVALID issued, all registers unchanged; read 0x2000 -> 32'hBAD0_ADD0; read 0x1040 (NUM_REGS=16) -> 32'hBAD0_ADD0.
REQ-036 SHALL cover: BREADY held low 7 cycles and RREADY held low 7 cycles -> BVALID/RVALID stay high, RDATA stable, AWREADY/WREADY/ARREADY stay low.
REQ-037 SHALL cover: reg 0x1008 = 32'h1, write 32'h2 and read 0x1008 committing/capturing same edge -> RDATA 32'h1; next read -> 32'h2.
REQ-038 SHALL cover: ARESET pulsed while BVALID=1 pending -> BVALID=0 immediately, registers read 32'h0 afterwards, readys high first cycle after release.
